router_pkt_tx: RTL and testbench
================================

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, byte width of data_out, wr_data, header and parity.
REQ-002 SHALL have parameter MAX_LEN, default 63, maximum payload bytes per packet (6-bit length field).
REQ-003 SHALL have ports: clock  in  1  single rising-edge clock.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 wr_en  in  1  payload write strobe.
REQ-006 wr_data  in  WIDTH  payload byte.
REQ-007 start  in  1  begin transmitting the buffered payload.
REQ-008 dest_addr  in  2  destination port, placed in header bits [1:0].
REQ-009 busy  in  1  downstream stall; byte not consumed while high.
REQ-010 pkt_valid  out  1  high during header and payload bytes, low during parity byte.
REQ-011 data_out  out  WIDTH  current packet byte.
REQ-012 tx_active  out  1  high in HEADER, PAYLOAD and PARITY.
REQ-013 wr_full  out  1  buffer holds MAX_LEN bytes.
REQ-014 done  out  1  one-cycle pulse after parity byte consumed.

Function
REQ-015 SHALL buffer payload in a MAX_LEN x WIDTH array with write pointer/count; in IDLE, each wr_en with wr_full low stores wr_data and increments count.
REQ-016 SHALL drop wr_en when wr_full is high, outside IDLE, or coincident with an accepted start.
REQ-017 SHALL implement states IDLE, HEADER, PAYLOAD, PARITY; all outputs registered.
REQ-018 In IDLE, start with count>=1 SHALL at that edge latch length=count, set data_out={count[5:0],dest_addr}, pkt_valid=1, parity accumulator=header, enter HEADER; start with count=0 SHALL be ignored.
REQ-019 A byte is consumed at a rising edge where tx_active=1 and busy=0; when busy=1, state, data_out, pkt_valid and read pointer SHALL hold.
REQ-020 HEADER consumed -> present buffer[0], enter PAYLOAD; each consumed payload byte XORs into accumulator and advances read pointer.
REQ-021 After the last payload byte (index length-1) is consumed, SHALL present data_out=accumulator including that byte, pkt_valid=0, enter PARITY.
REQ-022 PARITY consumed -> IDLE, data_out=0, tx_active=0, count and pointers cleared, done=1 for exactly one cycle.
REQ-023 Parity SHALL equal XOR of header and all payload bytes, WIDTH bits, no carry.
REQ-024 start outside IDLE SHALL be ignored; back-to-back packets require refilling the buffer after done.

Reset
REQ-025 resetn low SHALL asynchronously force IDLE, pkt_valid=0, data_out=0, tx_active=0, done=0, wr_full=0, count, pointers and accumulator 0; buffer contents need not clear.
REQ-026 Reset mid-packet SHALL abandon the packet with no parity byte and no done pulse.

Configuration
REQ-027 With ROUTER_TX_PARITY_ERR_INJ_EN defined, SHALL add input corrupt_parity (1 bit), sampled on the edge entering PARITY; if high, transmitted parity bit 0 SHALL be inverted.
REQ-028 Without ROUTER_TX_PARITY_ERR_INJ_EN, port corrupt_parity SHALL not exist and parity is always correct.

Verification
REQ-029 Write 0x11,0x22,0x33; start with dest_addr=2, busy=0 -> consecutive bytes 0x0E,0x11,0x22,0x33 with pkt_valid=1, then 0x0E with pkt_valid=0, done pulse one cycle later.
REQ-030 Same packet, busy high 3 cycles while 0x22 presented -> 0x22 held 4 cycles, sequence and parity unchanged.
REQ-031 Write 64 bytes -> wr_full=1 after 63rd, 64th dropped, header=0xFC|dest_addr, 63 payload bytes sent.
REQ-032 start with empty buffer -> tx_active stays 0, no output; wr_en during PAYLOAD -> buffer unchanged.
REQ-033 resetn low during PAYLOAD -> outputs 0 immediately (asynchronously), no done; next packet after refill correct.
REQ-034 With ROUTER_TX_PARITY_ERR_INJ_EN, corrupt_parity=1 on REQ-029 packet -> parity byte 0x0F.

Source files
------------

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers payload bytes, then sends header, payload and XOR parity.
// Optional parity error injection is enabled by defining ROUTER_TX_PARITY_ERR_INJ_EN.
module router_pkt_tx #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 63
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic [1:0]       dest_addr,
    input  logic             busy,
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
    input  logic             corrupt_parity,
`endif
    output logic             pkt_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             tx_active,
    output logic             wr_full,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PARITY} state_t;

    localparam logic [5:0] FULL_CNT = 6'(MAX_LEN);

    state_t           state;
    logic [WIDTH-1:0] mem [0:MAX_LEN-1];
    logic [5:0]       count;
    logic [5:0]       length;
    logic [5:0]       rd_ptr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] next_acc;
    logic [WIDTH-1:0] flip;
    logic             start_ok;
    logic             wr_ok;
    logic             consume;

    // Header carries the 6-bit length above the 2-bit destination; upper bits zero.
    function automatic logic [WIDTH-1:0] make_header(input logic [5:0] len,
                                                     input logic [1:0] dest);
        logic [WIDTH-1:0] h;
        h      = '0;
        h[7:0] = {len, dest};
        return h;
    endfunction

`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
    assign flip = {{(WIDTH-1){1'b0}}, corrupt_parity};
`else
    assign flip = '0;
`endif

    assign start_ok = (state == IDLE) && start && (count != 6'd0);
    assign wr_ok    = (state == IDLE) && wr_en && !wr_full && !start_ok;
    assign consume  = tx_active && !busy;
    assign next_acc = acc ^ data_out;

    // Count doubles as the write pointer; the buffer itself is never reset.
    always_ff @(posedge clock) begin
        if (wr_ok)
            mem[count] <= wr_data;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            pkt_valid <= 1'b0;
            data_out  <= '0;
            tx_active <= 1'b0;
            wr_full   <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            length    <= '0;
            rd_ptr    <= '0;
            acc       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        length    <= count;
                        data_out  <= make_header(count, dest_addr);
                        acc       <= make_header(count, dest_addr);
                        pkt_valid <= 1'b1;
                        tx_active <= 1'b1;
                        rd_ptr    <= '0;
                        state     <= HEADER;
                    end else if (wr_ok) begin
                        count   <= count + 6'd1;
                        wr_full <= (count + 6'd1) == FULL_CNT;
                    end
                end
                HEADER: begin
                    if (consume) begin
                        data_out <= mem[0];
                        rd_ptr   <= 6'd1;
                        state    <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    // rd_ptr is the index of the byte after the one being presented.
                    if (consume) begin
                        acc <= next_acc;
                        if (rd_ptr == length) begin
                            data_out  <= next_acc ^ flip;
                            pkt_valid <= 1'b0;
                            state     <= PARITY;
                        end else begin
                            data_out <= mem[rd_ptr];
                            rd_ptr   <= rd_ptr + 6'd1;
                        end
                    end
                end
                PARITY: begin
                    if (consume) begin
                        data_out  <= '0;
                        tx_active <= 1'b0;
                        count     <= '0;
                        length    <= '0;
                        rd_ptr    <= '0;
                        acc       <= '0;
                        wr_full   <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed testbench for router_pkt_tx with hand-computed packet bytes.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       resetn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       start;
    logic [1:0] dest_addr;
    logic       busy;
    logic       corrupt_parity;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_active;
    logic       wr_full;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    router_pkt_tx #(.WIDTH(8), .MAX_LEN(63)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .start         (start),
        .dest_addr     (dest_addr),
        .busy          (busy),
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
        .corrupt_parity(corrupt_parity),
`endif
        .pkt_valid     (pkt_valid),
        .data_out      (data_out),
        .tx_active     (tx_active),
        .wr_full       (wr_full),
        .done          (done)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0;
        dest_addr = '0; busy = 1'b0; corrupt_parity = 1'b0;
        step(); step();
        n_checks++;
        if ({pkt_valid, data_out, tx_active, wr_full, done} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got pv=%b do=%h act=%b full=%b done=%b, want all 0",
                     pkt_valid, data_out, tx_active, wr_full, done);
        end
        resetn = 1'b1;
        step();
    endtask

    // Three-byte packet to port 2: 0E 11 22 33 then parity 0E.
    task automatic test_basic(input string tag);
        logic [7:0] exp_b [0:3];
        exp_b[0] = 8'h0E; exp_b[1] = 8'h11; exp_b[2] = 8'h22; exp_b[3] = 8'h33;
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
        start = 1'b1; dest_addr = 2'd2;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (data_out !== exp_b[i] || pkt_valid !== 1'b1 || tx_active !== 1'b1) begin
                n_fail++;
                $display("FAIL %s byte%0d: got %h pv=%b act=%b, want %h pv=1 act=1",
                         tag, i, data_out, pkt_valid, tx_active, exp_b[i]);
            end
            step();
        end
        n_checks++;
        if (data_out !== 8'h0E || pkt_valid !== 1'b0 || tx_active !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s parity: got %h pv=%b act=%b done=%b, want 0e pv=0 act=1 done=0",
                     tag, data_out, pkt_valid, tx_active, done);
        end
        step();
        n_checks++;
        if (done !== 1'b1 || tx_active !== 1'b0 || data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL %s done_pulse: got done=%b act=%b do=%h, want 1 0 00",
                     tag, done, tx_active, data_out);
        end
        step();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_width: got done=%b, want 0", tag, done);
        end
    endtask

    task automatic test_busy();
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
        start = 1'b1; dest_addr = 2'd2;
        step();
        start = 1'b0;
        step();
        step();
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (data_out !== 8'h22 || pkt_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_hold%0d: got %h pv=%b, want 22 pv=1", i, data_out, pkt_valid);
            end
            step();
        end
        busy = 1'b0;
        n_checks++;
        if (data_out !== 8'h22) begin
            n_fail++;
            $display("FAIL busy_hold3: got %h, want 22", data_out);
        end
        step();
        n_checks++;
        if (data_out !== 8'h33 || pkt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after: got %h pv=%b, want 33 pv=1", data_out, pkt_valid);
        end
        step();
        n_checks++;
        if (data_out !== 8'h0E || pkt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_parity: got %h pv=%b, want 0e pv=0", data_out, pkt_valid);
        end
        step();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_done: got %b, want 1", done);
        end
        step();
    endtask

    // Payload 1..63; XOR of 1..63 is 0, so parity equals the header FD.
    task automatic test_full();
        for (int i = 1; i <= 63; i++) write_byte(8'(i));
        n_checks++;
        if (wr_full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_flag: got %b, want 1", wr_full);
        end
        write_byte(8'h40);
        start = 1'b1; dest_addr = 2'd1;
        step();
        start = 1'b0;
        n_checks++;
        if (data_out !== 8'hFD || pkt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_header: got %h pv=%b, want fd pv=1", data_out, pkt_valid);
        end
        for (int i = 1; i <= 63; i++) begin
            step();
            n_checks++;
            if (data_out !== 8'(i) || pkt_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL full_payload%0d: got %h pv=%b, want %h pv=1",
                         i, data_out, pkt_valid, 8'(i));
            end
        end
        step();
        n_checks++;
        if (data_out !== 8'hFD || pkt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_parity: got %h pv=%b, want fd pv=0", data_out, pkt_valid);
        end
        step();
        n_checks++;
        if (done !== 1'b1 || wr_full !== 1'b0) begin
            n_fail++;
            $display("FAIL full_done: got done=%b full=%b, want 1 0", done, wr_full);
        end
        step();
    endtask

    task automatic test_empty_and_drop();
        start = 1'b1; dest_addr = 2'd3;
        step();
        start = 1'b0;
        n_checks++;
        if (tx_active !== 1'b0 || pkt_valid !== 1'b0 || data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL empty_start: got act=%b pv=%b do=%h, want 0 0 00",
                     tx_active, pkt_valid, data_out);
        end
        // One-byte packet AA to port 0: header 04, parity AE; write during payload dropped.
        write_byte(8'hAA);
        start = 1'b1; dest_addr = 2'd0;
        step();
        start = 1'b0;
        n_checks++;
        if (data_out !== 8'h04) begin
            n_fail++;
            $display("FAIL drop_header: got %h, want 04", data_out);
        end
        step();
        write_byte(8'h55);
        n_checks++;
        if (data_out !== 8'hAE || pkt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_parity: got %h pv=%b, want ae pv=0", data_out, pkt_valid);
        end
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (tx_active !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_buffer: got act=%b, want 0 (buffer must be empty)", tx_active);
        end
    endtask

    task automatic test_reset_mid();
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
        start = 1'b1; dest_addr = 2'd2;
        step();
        start = 1'b0;
        step();
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({pkt_valid, data_out, tx_active, done} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_async: got pv=%b do=%h act=%b done=%b, want all 0",
                     pkt_valid, data_out, tx_active, done);
        end
        step();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (done !== 1'b0 || tx_active !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_nodone%0d: got done=%b act=%b, want 0 0", i, done, tx_active);
            end
        end
        test_basic("after_reset");
    endtask

`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
    task automatic test_corrupt();
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
        corrupt_parity = 1'b1;
        start = 1'b1; dest_addr = 2'd2;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (data_out !== 8'h0F || pkt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL corrupt_parity: got %h pv=%b, want 0f pv=0", data_out, pkt_valid);
        end
        corrupt_parity = 1'b0;
        step();
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_basic("basic");
        test_busy();
        test_full();
        test_empty_and_drop();
        test_reset_mid();
`ifdef ROUTER_TX_PARITY_ERR_INJ_EN
        test_corrupt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
